cshm_fir_ctrl: RTL and testbench

Stream and coefficient controller for the 4-tap CSHM transposed FIR datapath. Accepts input samples over a valid/ready handshake and drives the filter's sample input every cycle, inserting zero samples in gaps. Holds a shadow coefficient bank written by a host and commits it to the filter only after the datapath's inter-adder delay registers have been flushed. Tags filter outputs that correspond to real input samples and reports arithmetic overflow.

---
 rtl/cshm_fir_pkg.sv | 9 +
 rtl/cshm_coef_bank.sv | 23 ++
 rtl/cshm_fir_ctrl.sv | 87 ++++++++
 tb/tb_cshm_fir_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cshm_fir_pkg.sv
// cshm_fir_pkg: shared widths, drain length and controller state encoding for the CSHM FIR controller.
package cshm_fir_pkg;
  localparam int XW = 8;
  localparam int CW = 9;
  localparam int YW = 16;
  localparam int NTAPS = 4;
  localparam int DRAIN_CYCLES = NTAPS - 1;
  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;
endpackage

// File: rtl/cshm_coef_bank.sv
// cshm_coef_bank: host-written shadow coefficient bank copied into the active bank on a swap strobe.
module cshm_coef_bank
  import cshm_fir_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr,
  input  logic [1:0]                addr,
  input  logic [CW-1:0]             data,
  input  logic                      swap,
  output logic [NTAPS-1:0][CW-1:0]  active
);
  logic [NTAPS-1:0][CW-1:0] shadow;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr) shadow[addr] <= data;
      if (swap) active <= shadow;
    end
  end
endmodule

// File: rtl/cshm_fir_ctrl.sv
// cshm_fir_ctrl: sample stream, coefficient commit and output tagging for the 4-tap CSHM FIR.
// CSHM_FIR_OVF_STICKY_EN makes ovf_flag sticky until ovf_clr.
module cshm_fir_ctrl
  import cshm_fir_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  input  logic          cfg_wr,
  input  logic [1:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  input  logic          cfg_commit,
  output logic          cfg_busy,
  output logic [XW-1:0] fir_x,
  output logic [CW-1:0] fir_c0,
  output logic [CW-1:0] fir_c1,
  output logic [CW-1:0] fir_c2,
  output logic [CW-1:0] fir_c3,
  input  logic [YW-1:0] fir_y,
  input  logic          fir_ovf,
  output logic          out_valid,
  output logic [YW-1:0] out_y,
  output logic          ovf_flag,
  input  logic          ovf_clr
);
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic vld_d, accept;
  logic [NTAPS-1:0][CW-1:0] coef;
  assign in_ready = state == RUN;
  assign cfg_busy = ~in_ready;
  assign accept = in_valid & in_ready;
  assign out_y = fir_y;
  assign {fir_c3, fir_c2, fir_c1, fir_c0} = coef;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      RUN: begin
        state_n = cfg_commit ? DRAIN : RUN;
        cnt_n = 2'(DRAIN_CYCLES - 1);
      end
      DRAIN: begin
        state_n = cnt == 2'd0 ? SWAP : DRAIN;
        cnt_n = cnt == 2'd0 ? cnt : cnt - 2'd1;
      end
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      fir_x <= '0;
      vld_d <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      fir_x <= accept ? in_x : '0;
      vld_d <= accept;
      out_valid <= vld_d;
    end
  end
  // shadow writes only land while the stream is running
  cshm_coef_bank u_bank (
    .clk    (clk),
    .reset  (reset),
    .wr     (cfg_wr & in_ready),
    .addr   (cfg_addr),
    .data   (cfg_data),
    .swap   (state == SWAP),
    .active (coef)
  );
`ifdef CSHM_FIR_OVF_STICKY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_flag <= 1'b0;
    else ovf_flag <= (fir_ovf & out_valid) | (ovf_flag & ~ovf_clr);
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_flag = fir_ovf & out_valid;
`endif
endmodule

// File: tb/tb_cshm_fir_ctrl.sv
// tb_cshm_fir_ctrl: randomized bench with a transposed-FIR stub and a convolution-level reference model.
module tb_cshm_fir_ctrl;
  logic clk = 0, reset = 1, in_valid = 0, cfg_wr = 0, cfg_commit = 0, ovf_clr = 0;
  logic [7:0] in_x = 0;
  logic [1:0] cfg_addr = 0;
  logic [8:0] cfg_data = 0;
  logic in_ready, cfg_busy, out_valid, ovf_flag, fir_ovf;
  logic [7:0] fir_x;
  logic [8:0] fir_c0, fir_c1, fir_c2, fir_c3;
  logic [15:0] fir_y, out_y;
  int ntot = 0, npass = 0;

  cshm_fir_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .fir_x(fir_x), .fir_c0(fir_c0), .fir_c1(fir_c1), .fir_c2(fir_c2),
    .fir_c3(fir_c3), .fir_y(fir_y), .fir_ovf(fir_ovf), .out_valid(out_valid), .out_y(out_y),
    .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // filter stand-in: transposed 4-tap FIR with a registered, unbounded-precision output
  int q1, q2, q3, yf;
  int xs;
  assign xs = int'($signed(fir_x));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1 <= 0; q2 <= 0; q3 <= 0; yf <= 0;
    end else begin
      yf <= int'($signed(fir_c0)) * xs + q1;
      q1 <= int'($signed(fir_c1)) * xs + q2;
      q2 <= int'($signed(fir_c2)) * xs + q3;
      q3 <= int'($signed(fir_c3)) * xs;
    end
  end
  assign fir_y = yf[15:0];
  assign fir_ovf = (yf > 32767) || (yf < -32768);

  // reference model: accepted-sample stream convolved with the bank active when each output forms
  int act[4], sh[4], hist[4];
  int busy, ey, nacc, nvld;
  bit vld_last, eov, eflag, eready, ebusy, obs_ready;
  logic [7:0] ex;

  function automatic bit ovf_of(input int y);
    return (y > 32767) || (y < -32768);
  endfunction

  task automatic mreset();
    for (int k = 0; k < 4; k++) begin act[k] = 0; sh[k] = 0; hist[k] = 0; end
    busy = 0; ey = 0; vld_last = 0; eov = 0; eflag = 0; ex = 0; ebusy = 0; eready = 1;
  endtask

  task automatic cyc(input bit v, input int x, input bit wr, input int a, input int d, input bit cm, input bit clr);
    bit acc;
    int s;
    in_valid = v; in_x = 8'(x); cfg_wr = wr; cfg_addr = 2'(a); cfg_data = 9'(d); cfg_commit = cm; ovf_clr = clr;
    #1 obs_ready = in_ready;
    eready = (busy == 0);
    acc = v && eready;
`ifdef CSHM_FIR_OVF_STICKY_EN
    eflag = (ovf_of(ey) && eov) || (eflag && !clr);
`endif
    s = 0;
    for (int k = 0; k < 4; k++) s += act[k] * hist[k];
    ey = s;
    eov = vld_last;
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = acc ? x : 0;
    vld_last = acc;
    ex = acc ? 8'(x) : 8'h00;
    nacc += int'(acc);
    if (eready) begin
      if (wr) sh[a] = d;
      if (cm) busy = 4;
    end else begin
      busy--;
      if (busy == 0) act = sh;
    end
`ifndef CSHM_FIR_OVF_STICKY_EN
    eflag = ovf_of(ey) && eov;
`endif
    ebusy = (busy != 0);
    @(posedge clk);
    @(negedge clk);
    nvld += int'(out_valid);
  endtask

  function automatic int rx();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic int rc();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic load(input int c0, input int c1, input int c2, input int c3);
    cyc(0, 0, 1, 0, c0, 0, 0);
    cyc(0, 0, 1, 1, c1, 0, 0);
    cyc(0, 0, 1, 2, c2, 0, 0);
    cyc(0, 0, 1, 3, c3, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    mreset();
    nacc = 0; nvld = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    cyc(1, 17, 1, 0, 7, 0, 0);
    cyc(1, -40, 1, 1, 3, 1, 0);
    cyc(1, 9, 0, 0, 0, 0, 0);
    #2 reset = 1;
    #1;
    ntot++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", in_ready); else npass++;
    ntot++; if (cfg_busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", cfg_busy); else npass++;
    ntot++; if (fir_x !== 8'h00) $display("FAIL rst_fir_x got %h exp 00", fir_x); else npass++;
    ntot++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else npass++;
    ntot++; if ({fir_c0, fir_c1, fir_c2, fir_c3} !== 36'h0) $display("FAIL rst_coef got %h exp 0", {fir_c0, fir_c1, fir_c2, fir_c3}); else npass++;
    ntot++; if (ovf_flag !== 1'b0) $display("FAIL rst_ovf_flag got %b exp 0", ovf_flag); else npass++;
    ntot++; if (out_y !== 16'h0) $display("FAIL rst_out_y got %h exp 0", out_y); else npass++;
    mreset();
    in_valid = 0; cfg_wr = 0; cfg_commit = 0;
    @(negedge clk);
    reset = 0;
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    ntot++; if ({fir_c0, fir_c1, fir_c2, fir_c3} !== {9'(act[0]), 9'(act[1]), 9'(act[2]), 9'(act[3])})
      $display("FAIL rst_shadow_lost got %h exp %h", {fir_c0, fir_c1, fir_c2, fir_c3}, {9'(act[0]), 9'(act[1]), 9'(act[2]), 9'(act[3])}); else npass++;
  endtask

  task automatic test_coef_load();
    int nbusy;
    cyc(0, 0, 1, 0, 2, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0);
    cyc(0, 0, 1, 2, 3, 0, 0);
    cyc(0, 0, 1, 3, 4, 1, 0);
    nbusy = int'(cfg_busy);
    for (int i = 0; i < 4; i++) begin
      cyc(1, rx(), 1, i, 100 + i, 1, 0);
      nbusy += int'(cfg_busy);
      ntot++; if (obs_ready !== eready) $display("FAIL load_ready cyc %0d got %b exp %b", i, obs_ready, eready); else npass++;
      ntot++; if (cfg_busy !== ebusy) $display("FAIL load_busy cyc %0d got %b exp %b", i, cfg_busy, ebusy); else npass++;
      ntot++; if ({fir_c0, fir_c1, fir_c2, fir_c3} !== {9'(act[0]), 9'(act[1]), 9'(act[2]), 9'(act[3])})
        $display("FAIL load_coef cyc %0d got %h exp %h", i, {fir_c0, fir_c1, fir_c2, fir_c3}, {9'(act[0]), 9'(act[1]), 9'(act[2]), 9'(act[3])}); else npass++;
    end
    ntot++; if (nbusy !== 4) $display("FAIL load_busy_len got %0d exp 4", nbusy); else npass++;
    ntot++; if ({fir_c0, fir_c1, fir_c2, fir_c3} !== {9'd2, 9'd1, 9'd3, 9'd4}) $display("FAIL load_active got %h exp %h", {fir_c0, fir_c1, fir_c2, fir_c3}, {9'd2, 9'd1, 9'd3, 9'd4}); else npass++;
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    ntot++; if ({fir_c0, fir_c1, fir_c2, fir_c3} !== {9'd2, 9'd1, 9'd3, 9'd4}) $display("FAIL load_busy_wr_ignored got %h exp %h", {fir_c0, fir_c1, fir_c2, fir_c3}, {9'd2, 9'd1, 9'd3, 9'd4}); else npass++;
  endtask

  task automatic test_stream();
    int xs4[4] = '{-3, 1, 0, -2};
    nacc = 0; nvld = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(i < 4, i < 4 ? xs4[i] : 0, 0, 0, 0, 0, 0);
      ntot++; if (fir_x !== ex) $display("FAIL stream_fir_x cyc %0d got %h exp %h", i, fir_x, ex); else npass++;
      ntot++; if (out_valid !== eov) $display("FAIL stream_out_valid cyc %0d got %b exp %b", i, out_valid, eov); else npass++;
      ntot++; if (out_y !== 16'(ey)) $display("FAIL stream_out_y cyc %0d got %0d exp %0d", i, $signed(out_y), ey); else npass++;
    end
    ntot++; if (nvld !== 4) $display("FAIL stream_pulses got %0d exp 4", nvld); else npass++;
  endtask

  task automatic test_gap();
    load(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(i == 0 || i == 2, 5, 0, 0, 0, 0, 0);
      ntot++; if (out_valid !== eov) $display("FAIL gap_out_valid cyc %0d got %b exp %b", i, out_valid, eov); else npass++;
      ntot++; if (out_y !== 16'(ey)) $display("FAIL gap_out_y cyc %0d got %0d exp %0d", i, $signed(out_y), ey); else npass++;
    end
  endtask

  task automatic test_midstream();
    nacc = 0; nvld = 0;
    for (int i = 0; i < 28; i++) begin
      cyc(1, rx(), i < 10, i % 4, rc(), i == 9, 0);
      ntot++; if (obs_ready !== eready) $display("FAIL mid_ready cyc %0d got %b exp %b", i, obs_ready, eready); else npass++;
      ntot++; if (cfg_busy !== ebusy) $display("FAIL mid_busy cyc %0d got %b exp %b", i, cfg_busy, ebusy); else npass++;
      ntot++; if (out_valid !== eov) $display("FAIL mid_out_valid cyc %0d got %b exp %b", i, out_valid, eov); else npass++;
      ntot++; if (out_y !== 16'(ey)) $display("FAIL mid_out_y cyc %0d got %0d exp %0d", i, $signed(out_y), ey); else npass++;
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    ntot++; if (nvld !== nacc) $display("FAIL mid_no_loss got %0d exp %0d", nvld, nacc); else npass++;
  endtask

  task automatic test_overflow();
    bit saw = 0;
    load(255, 255, 255, 255);
    for (int i = 0; i < 14; i++) begin
      cyc(i < 4, -128, 0, 0, 0, 0, i == 11);
      saw |= ovf_flag;
      ntot++; if (ovf_flag !== eflag) $display("FAIL ovf_flag cyc %0d got %b exp %b", i, ovf_flag, eflag); else npass++;
      ntot++; if (out_y !== 16'(ey)) $display("FAIL ovf_out_y cyc %0d got %0d exp %0d", i, $signed(out_y), ey); else npass++;
    end
    ntot++; if (saw !== 1'b1) $display("FAIL ovf_rise got %b exp 1", saw); else npass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 7, rx(), $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)), rc(),
          $urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0);
      ntot++; if (obs_ready !== eready) $display("FAIL rnd_ready cyc %0d got %b exp %b", i, obs_ready, eready); else npass++;
      ntot++; if (cfg_busy !== ebusy) $display("FAIL rnd_busy cyc %0d got %b exp %b", i, cfg_busy, ebusy); else npass++;
      ntot++; if (fir_x !== ex) $display("FAIL rnd_fir_x cyc %0d got %h exp %h", i, fir_x, ex); else npass++;
      ntot++; if (out_valid !== eov) $display("FAIL rnd_out_valid cyc %0d got %b exp %b", i, out_valid, eov); else npass++;
      ntot++; if (out_y !== 16'(ey)) $display("FAIL rnd_out_y cyc %0d got %0d exp %0d", i, $signed(out_y), ey); else npass++;
      ntot++; if (ovf_flag !== eflag) $display("FAIL rnd_ovf_flag cyc %0d got %b exp %b", i, ovf_flag, eflag); else npass++;
      ntot++; if ({fir_c0, fir_c1, fir_c2, fir_c3} !== {9'(act[0]), 9'(act[1]), 9'(act[2]), 9'(act[3])})
        $display("FAIL rnd_coef cyc %0d got %h exp %h", i, {fir_c0, fir_c1, fir_c2, fir_c3}, {9'(act[0]), 9'(act[1]), 9'(act[2]), 9'(act[3])}); else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_coef_load();
    test_stream();
    test_gap();
    test_midstream();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
